// File: rtl/adam_jtag_pause_tap.sv
// JTAG TAP, oversampled in the ADAM_SEQ clock, giving a probe run/stop
// control of one domain through its ADAM_PAUSE handshake.
module adam_jtag_pause_tap #(
  parameter logic [31:0] IDCODE         = 32'h1ADA_0001,
  parameter int          SYNC_STAGES    = 2,
  parameter logic        PAUSE_ON_RESET = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic jtag_trst_n,
  input  logic jtag_tck,
  input  logic jtag_tms,
  input  logic jtag_tdi,
  output logic jtag_tdo,
  output logic pause_req,
  input  logic pause_ack,
  output logic paused
);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_t;

  localparam logic [3:0] IR_IDCODE = 4'h1;
  localparam logic [3:0] IR_PAUSE  = 4'h8;

  logic [SYNC_STAGES-1:0] tck_sync;
  logic [SYNC_STAGES-1:0] tms_sync;
  logic [SYNC_STAGES-1:0] tdi_sync;
  logic [SYNC_STAGES-1:0] trst_sync;
  logic                   tck_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tck_sync  <= '0;
      tms_sync  <= '1;
      tdi_sync  <= '0;
      trst_sync <= '0;
      tck_q     <= 1'b0;
    end else begin
      tck_sync  <= (tck_sync << 1) | SYNC_STAGES'(jtag_tck);
      tms_sync  <= (tms_sync << 1) | SYNC_STAGES'(jtag_tms);
      tdi_sync  <= (tdi_sync << 1) | SYNC_STAGES'(jtag_tdi);
      trst_sync <= (trst_sync << 1) | SYNC_STAGES'(jtag_trst_n);
      tck_q     <= tck_sync[SYNC_STAGES-1];
    end
  end

  logic tck_s, tms_s, tdi_s, trst_s;
  logic tck_rise, tck_fall;

  assign tck_s    = tck_sync[SYNC_STAGES-1];
  assign tms_s    = tms_sync[SYNC_STAGES-1];
  assign tdi_s    = tdi_sync[SYNC_STAGES-1];
  assign trst_s   = trst_sync[SYNC_STAGES-1];
  assign tck_rise = tck_s & ~tck_q;
  assign tck_fall = ~tck_s & tck_q;

  function automatic tap_t tap_next(input tap_t s, input logic tms);
    case (s)
      TLR:     tap_next = tms ? TLR    : RTI;
      RTI:     tap_next = tms ? SEL_DR : RTI;
      SEL_DR:  tap_next = tms ? SEL_IR : CAP_DR;
      CAP_DR:  tap_next = tms ? EX1_DR : SH_DR;
      SH_DR:   tap_next = tms ? EX1_DR : SH_DR;
      EX1_DR:  tap_next = tms ? UPD_DR : PA_DR;
      PA_DR:   tap_next = tms ? EX2_DR : PA_DR;
      EX2_DR:  tap_next = tms ? UPD_DR : SH_DR;
      UPD_DR:  tap_next = tms ? SEL_DR : RTI;
      SEL_IR:  tap_next = tms ? TLR    : CAP_IR;
      CAP_IR:  tap_next = tms ? EX1_IR : SH_IR;
      SH_IR:   tap_next = tms ? EX1_IR : SH_IR;
      EX1_IR:  tap_next = tms ? UPD_IR : PA_IR;
      PA_IR:   tap_next = tms ? EX2_IR : PA_IR;
      EX2_IR:  tap_next = tms ? UPD_IR : SH_IR;
      UPD_IR:  tap_next = tms ? SEL_DR : RTI;
      default: tap_next = TLR;
    endcase
  endfunction

  tap_t        state;
  tap_t        nxt;
  logic [3:0]  ir;
  logic [3:0]  ir_sr;
  logic [31:0] id_sr;
  logic        byp_sr;
  logic [1:0]  ps_sr;
  logic        pending;
  logic        sel_id, sel_pause;
  logic        dr_lsb;

  assign nxt = tap_next(state, tms_s);

  always_comb begin
    sel_id    = 1'b0;
    sel_pause = 1'b0;
    dr_lsb    = byp_sr;
    unique case (1'b1)
      (ir == IR_IDCODE): begin
        sel_id = 1'b1;
        dr_lsb = id_sr[0];
      end
      (ir == IR_PAUSE): begin
        sel_pause = 1'b1;
        dr_lsb    = ps_sr[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= TLR;
      ir        <= IR_IDCODE;
      ir_sr     <= '0;
      id_sr     <= '0;
      byp_sr    <= 1'b0;
      ps_sr     <= '0;
      jtag_tdo  <= 1'b0;
      pending   <= PAUSE_ON_RESET;
      pause_req <= PAUSE_ON_RESET;
    end else begin
      // request only moves while the handshake is idle
      if (pause_req == pause_ack && pending != pause_req)
        pause_req <= pending;
      if (!trst_s) begin
        state <= TLR;
        ir    <= IR_IDCODE;
      end else if (tck_rise) begin
        state <= nxt;
        case (state)
          TLR:    ir    <= IR_IDCODE;
          CAP_IR: ir_sr <= 4'b0101;
          SH_IR:  ir_sr <= {tdi_s, ir_sr[3:1]};
          CAP_DR: begin
            if (sel_id)    id_sr  <= IDCODE;
            if (sel_pause) ps_sr  <= {pause_ack, pause_req};
            if (!sel_id && !sel_pause) byp_sr <= 1'b0;
          end
          SH_DR: begin
            if (sel_id)    id_sr  <= {tdi_s, id_sr[31:1]};
            if (sel_pause) ps_sr  <= {tdi_s, ps_sr[1]};
            if (!sel_id && !sel_pause) byp_sr <= tdi_s;
          end
          default: ;
        endcase
        if (nxt == UPD_IR) ir <= ir_sr;
        if (nxt == UPD_DR && sel_pause) pending <= ps_sr[0];
      end
      if (tck_fall) begin
        jtag_tdo <= (state == SH_IR) ? ir_sr[0] :
                    (state == SH_DR) ? dr_lsb : 1'b0;
      end
    end
  end

  assign paused = pause_req & pause_ack;

endmodule

// File: tb/tb_adam_jtag_pause_tap.sv
// Bench for adam_jtag_pause_tap: bit-banged probe scans checked
// against a scoreboard of expected TDO words.
module tb_adam_jtag_pause_tap;

  localparam int HALF = 6;
  localparam logic [31:0] ID = 32'h1ADA_0001;

  logic clk = 1'b0;
  logic rst_n, jtag_trst_n, jtag_tck, jtag_tms, jtag_tdi;
  logic jtag_tdo, pause_req, pause_ack, paused;

  int n_chk  = 0;
  int n_pass = 0;
  logic tdo_s = 1'b0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  adam_jtag_pause_tap dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .jtag_trst_n (jtag_trst_n),
    .jtag_tck    (jtag_tck),
    .jtag_tms    (jtag_tms),
    .jtag_tdi    (jtag_tdi),
    .jtag_tdo    (jtag_tdo),
    .pause_req   (pause_req),
    .pause_ack   (pause_ack),
    .paused      (paused)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tck_cycle(input logic tms, input logic tdi);
    @(negedge clk);
    jtag_tms = tms;
    jtag_tdi = tdi;
    jtag_tck = 1'b1;
    repeat (HALF) @(negedge clk);
    jtag_tck = 1'b0;
    repeat (HALF) @(negedge clk);
    tdo_s = jtag_tdo;
  endtask

  // From Run-Test/Idle: scan n bits, back to idle unless hold_ex1.
  task automatic scan(input logic is_ir, input int n,
                      input logic [31:0] din, input logic [31:0] exp,
                      input logic hold_ex1);
    logic [31:0] dout;
    dout = '0;
    sb.push_back(exp);
    tck_cycle(1'b1, 1'b0);
    if (is_ir) tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      dout[i] = tdo_s;
      tck_cycle(i == n - 1, din[i]);
    end
    if (!hold_ex1) begin
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
    end
    if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
    else chk(is_ir ? "ir_out" : "dr_out", dout, sb.pop_front());
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bp;
    rst_n       = 1'b0;
    jtag_trst_n = 1'b1;
    jtag_tck    = 1'b0;
    jtag_tms    = 1'b1;
    jtag_tdi    = 1'b0;
    pause_ack   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req", pause_req, 0);
    chk("rst_tdo", jtag_tdo, 0);
    chk("rst_paused", paused, 0);
    repeat (4) @(negedge clk);

    repeat (5) tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    scan(1'b0, 32, 32'h0, ID, 1'b0);

    scan(1'b1, 4, 32'hF, 32'h5, 1'b0);
    bp = 8'hA5;
    scan(1'b0, 8, 32'(bp), 32'(8'(bp << 1)), 1'b0);

    scan(1'b1, 4, 32'h8, 32'h5, 1'b0);
    scan(1'b0, 2, 32'h1, 32'h0, 1'b1);
    @(negedge clk);
    jtag_tms = 1'b1;
    jtag_tck = 1'b1;
    repeat (3) @(negedge clk);
    chk("req_pre", pause_req, 0);
    @(negedge clk);
    chk("req_rise", pause_req, 1);
    repeat (HALF - 4) @(negedge clk);
    jtag_tck = 1'b0;
    repeat (HALF) @(negedge clk);
    tck_cycle(1'b0, 1'b0);

    pause_ack = 1'b1;
    @(negedge clk);
    chk("paused_on", paused, 1);
    scan(1'b0, 2, 32'h1, 32'h3, 1'b0);

    pause_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("inflight_req", pause_req, 1);
    scan(1'b0, 2, 32'h1, 32'h1, 1'b0);
    scan(1'b0, 2, 32'h0, 32'h1, 1'b0);
    chk("req_hold", pause_req, 1);
    pause_ack = 1'b1;
    @(negedge clk);
    chk("req_fall", pause_req, 0);
    pause_ack = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_req", pause_req, 0);
    chk("idle_paused", paused, 0);

    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b1);
    @(negedge clk);
    jtag_trst_n = 1'b0;
    repeat (HALF) @(negedge clk);
    jtag_trst_n = 1'b1;
    repeat (HALF) @(negedge clk);
    chk("trst_req", pause_req, 0);
    tck_cycle(1'b0, 1'b0);
    scan(1'b0, 32, 32'h0, ID, 1'b0);
    repeat (4) @(negedge clk);
    chk("trst_req_end", pause_req, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/adam_jtag_pause_tap.md
# adam_jtag_pause_tap

Debug-access block that gives an external JTAG probe run/stop control of one ADAM power/clock domain. It implements an IEEE 1149.1 TAP controller oversampled in the system clock, with an instruction register, IDCODE, BYPASS and a PAUSE data register. The PAUSE data register drives the domain's ADAM_PAUSE request/acknowledge handshake. It sits between the chip-level ADAM_JTAG pins and the ADAM_PAUSE master port of the target domain, clocked by that domain's ADAM_SEQ.

## Interface

**Parameters**

- `IDCODE`, default `32'h1ADA_0001`. Value captured by the IDCODE instruction; bit 0 must be 1.
- `SYNC_STAGES`, default `2`. Flip-flop synchronizer depth applied to every JTAG input.
- `PAUSE_ON_RESET`, default `1'b0`. Value of `pause_req` and of the pending target after reset.

**Ports**

- `clk`, in, 1. ADAM_SEQ clock. The only clock in the block.
- `rst_n`, in, 1. ADAM_SEQ reset, synchronous, active-low.
- `jtag_trst_n`, in, 1. ADAM_JTAG test reset, asynchronous to `clk`, active-low.
- `jtag_tck`, in, 1. ADAM_JTAG test clock, asynchronous to `clk`.
- `jtag_tms`, in, 1. ADAM_JTAG mode select.
- `jtag_tdi`, in, 1. ADAM_JTAG data in.
- `jtag_tdo`, out, 1. ADAM_JTAG data out, registered.
- `pause_req`, out, 1. ADAM_PAUSE request; 1 = pause the domain, 0 = run it.
- `pause_ack`, in, 1. ADAM_PAUSE acknowledge; equals `pause_req` once the domain has settled.
- `paused`, out, 1. Status: `pause_req & pause_ack`.

## Operation

**Input conditioning**
- `jtag_tck`, `jtag_tms`, `jtag_tdi` and `jtag_trst_n` each pass through `SYNC_STAGES` flip-flops.
- One further register on the synchronized `tck` produces single-cycle `tck_rise` and `tck_fall` strobes.
- A synchronized `trst_n` of 0 forces the TAP to Test-Logic-Reset and the IR to IDCODE. It does not affect `pause_req`, the pending target or the handshake.

**TAP state machine**
- Standard 16 states: Test-Logic-Reset, Run-Test/Idle, Select-DR/IR, Capture, Shift, Exit1, Pause, Exit2 and Update for both DR and IR.
- Transitions follow 1149.1, evaluated on `tck_rise` using the synchronized TMS.
- Five consecutive `tck_rise` events with TMS=1 reach Test-Logic-Reset from any state.

**Instruction register (4 bits)**
- Reset value: IDCODE (`0x1`).
- Capture-IR loads `4'b0101`.
- Shift is LSB first, from TDI toward TDO; Update-IR latches the shifted value.
- Decoding:
  - `0x1` selects IDCODE, a 32-bit DR.
  - `0x8` selects PAUSE, a 2-bit DR.
  - All other codes, including `0xF`, select BYPASS, a 1-bit DR.

**Data registers**
- IDCODE: Capture-DR loads `IDCODE`.
- BYPASS: Capture-DR loads 0.
- PAUSE:
  - Capture-DR loads `{pause_ack, pause_req}`.
  - On Update-DR, shifted bit 0 becomes the pending target; bit 1 is ignored.
- All data registers shift LSB first.

**TDO**
- On `tck_fall`, `jtag_tdo` is loaded with the LSB of the selected register while in Shift-DR or Shift-IR, and with 0 otherwise.

**Pause handshake**
- `pause_req` may change only when `pause_req == pause_ack` (idle).
- When idle and the pending target differs from `pause_req`, `pause_req` takes the pending target on the next `clk` edge.
- When a handshake is in flight, the pending target is held and applied once the handshake returns to idle.
- Multiple Update-DR writes during one in-flight handshake: the last write wins.

**Reset (`rst_n` = 0, sampled on `clk`)**
- TAP in Test-Logic-Reset, IR = `0x1`, all shift registers = 0.
- `jtag_tdo` = 0.
- `pause_req` = `PAUSE_ON_RESET`, pending target = `PAUSE_ON_RESET`.
- `paused` = `PAUSE_ON_RESET & pause_ack`.
- Synchronizer flip-flops reset to: `tck` = 0, `tms` = 1, `tdi` = 0, `trst_n` = 0.

## Timing

- `jtag_tck` high and low phases must each last at least `SYNC_STAGES+2` `clk` cycles; faster TCK is unsupported and produces no defined behaviour.
- Latency from a TCK rising edge at the pin to the TAP state and shift register update: `SYNC_STAGES+1` `clk` cycles.
- `jtag_tdo` changes `SYNC_STAGES+1` `clk` cycles after a TCK falling edge at the pin, and is stable before the next rising edge.
- `pause_req` changes exactly 1 `clk` cycle after the Update-DR state is entered, if the handshake is idle.
- `paused` is combinational from registered `pause_req` and the input `pause_ack`.
- Simultaneous `tck_rise` and `rst_n` = 0: reset wins.
- `rst_n` asserted mid-shift: the scan is aborted and the next probe access must restart from Test-Logic-Reset.

## Test plan

- **Reset values:** hold `rst_n` = 0 for 3 cycles, then release → `pause_req` = 0, `jtag_tdo` = 0, `paused` = 0, TAP in Test-Logic-Reset.
- **IDCODE:** 5× TMS=1, then shift 32 DR bits with no IR scan → TDO returns `0x1ADA0001`, LSB first.
- **IR capture and BYPASS:** IR scan of `0xF` → captured IR bits read back `0101`. Then a DR scan of 8 bits `0xA5` → TDO returns 0 followed by `0xA5` delayed by one bit.
- **Pause on and off:**
  - IR `0x8`, DR shift `2'b01` → `pause_req` rises 1 cycle after Update-DR.
  - Drive `pause_ack` = 1 → `paused` = 1.
  - A PAUSE DR capture now reads `2'b11`.
- **In-flight write deferral:**
  - With `pause_req` = 1 and `pause_ack` = 0, write 0 → `pause_req` stays 1.
  - Raise `pause_ack` → next cycle `pause_req` = 0.
  - Drop `pause_ack` → idle again.
- **trst mid-shift:** pulse `jtag_trst_n` low during Shift-DR of PAUSE → TAP returns to Test-Logic-Reset and IR = `0x1`; `pause_req` is unchanged.
